// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and a constant-evaluable log2 for sizing the iteration counter.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Operand/product handshake bundle: master feeds operands and drains products,
// slave is the multiplier.
interface seq_mul_if #(parameter int N = 8);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic           sgn;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] z;

  modport master (output in_valid, x, y, sgn, out_ready,
                  input  in_ready, out_valid, z);
  modport slave  (input  in_valid, x, y, sgn, out_ready,
                  output in_ready, out_valid, z);
endinterface

// File: rtl/seq_mul_dp.sv
// Datapath: sign-magnitude operand capture, shift-and-add accumulation and the
// final conditional negation into the product register.
module seq_mul_dp
  import mul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           finish,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  input  logic           sgn,
  output logic [2*N-1:0] z
);

  logic [2*N-1:0] mcand, acc, sum;
  logic [N-1:0]   mplier, ax, ay;
  logic           neg;

  // |-2^(N-1)| wraps to 2^(N-1), which is the correct unsigned magnitude
  assign ax  = (sgn & x[N-1]) ? (~x + 1'b1) : x;
  assign ay  = (sgn & y[N-1]) ? (~y + 1'b1) : y;
  assign sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      z      <= '0;
    end else if (load) begin
      mcand  <= {{N{1'b0}}, ax};
      mplier <= ay;
      acc    <= '0;
      neg    <= sgn & (x[N-1] ^ y[N-1]);
    end else if (step) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      // negating a zero sum wraps back to zero
      if (finish) z <= neg ? (~sum + 1'b1) : sum;
    end
  end

endmodule

// File: rtl/seq_mul.sv
// Sequential N x N multiplier, one multiplier bit per clock, valid/ready on
// both sides. Control FSM and iteration counter live here.
module seq_mul
  import mul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic    clk,
  input  logic    rst,
  seq_mul_if.slave bus
);

  localparam int CW = clog2(N + 1);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          load, step, finish;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (load)      cnt <= CW'(N);
      else if (step) cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    nxt    = state;
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        load = 1'b1;
        nxt  = BUSY;
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == CW'(1)) begin
          finish = 1'b1;
          nxt    = DONE;
        end
      end
      DONE: if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  seq_mul_dp #(.N(N)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .finish (finish),
    .x      (bus.x),
    .y      (bus.y),
    .sgn    (bus.sgn),
    .z      (bus.z)
  );

endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul: N=8 directed cases (latency, signed/unsigned,
// backpressure, reset) plus an exhaustive N=4 sweep in both modes.
module tb_seq_mul;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  seq_mul_if #(.N(8)) b8 ();
  seq_mul_if #(.N(4)) b4 ();

  seq_mul #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  seq_mul #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one N=8 operation from IDLE; returns when out_valid is seen.
  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] r, output int lat, output logic rdy_hi);
    b8.sgn = s; b8.x = a; b8.y = b; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 0; rdy_hi = 1'b0;
    while (!b8.out_valid && lat < 40) begin
      if (b8.in_ready) rdy_hi = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    r = b8.z;
  endtask

  task automatic idle8(input string tag);
    @(posedge clk); #1;
    chk(tag, {31'd0, b8.in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] r;
    int          lat, w, bad_lat;
    logic        rdy_hi;
    logic signed [3:0] sa, sb;
    int          p;

    rst = 1'b1;
    b8.in_valid = 1'b0; b8.x = '0; b8.y = '0; b8.sgn = 1'b0; b8.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.x = '0; b4.y = '0; b4.sgn = 1'b0; b4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {31'd0, b8.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, b8.out_valid}, 32'd0);
    chk("rst_z", {16'd0, b8.z}, 32'd0);

    // unsigned corner, latency and in_ready during operation
    op8(1'b0, 8'hFF, 8'hFF, r, lat, rdy_hi);
    chk("u_ff_ff", {16'd0, r}, 32'hFE01);
    chk("latency", lat, 8);
    chk("busy_in_ready", {31'd0, rdy_hi}, 32'd0);
    idle8("ready_after_hs");

    // signed mode
    op8(1'b1, 8'h80, 8'h80, r, lat, rdy_hi);
    chk("s_m128_m128", {16'd0, r}, 32'h4000);
    idle8("idle_s1");
    op8(1'b1, 8'hFD, 8'h05, r, lat, rdy_hi);
    chk("s_m3_5", {16'd0, r}, 32'hFFF1);
    idle8("idle_s2");
    op8(1'b1, 8'h00, 8'h80, r, lat, rdy_hi);
    chk("s_0_m128", {16'd0, r}, 32'h0000);
    idle8("idle_s3");

    // same bits unsigned
    op8(1'b0, 8'h80, 8'h80, r, lat, rdy_hi);
    chk("u_80_80", {16'd0, r}, 32'h4000);
    idle8("idle_u1");
    op8(1'b0, 8'hFD, 8'h05, r, lat, rdy_hi);
    chk("u_fd_05", {16'd0, r}, 32'h04F1);
    idle8("idle_u2");

    // backpressure: 12*13 = 156 held while new operands are offered
    b8.out_ready = 1'b0;
    op8(1'b0, 8'd12, 8'd13, r, lat, rdy_hi);
    for (int i = 0; i < 5; i++) begin
      b8.in_valid = 1'b1;
      b8.x = 8'(i * 17 + 3);
      b8.y = 8'(i * 29 + 1);
      @(posedge clk); #1;
      chk("bp_z", {16'd0, b8.z}, 32'h009C);
      chk("bp_out_valid", {31'd0, b8.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, b8.in_ready}, 32'd0);
    end
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {31'd0, b8.in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, b8.out_valid}, 32'd0);
    chk("z_retained", {16'd0, b8.z}, 32'h009C);

    // reset on the third iteration discards the operation
    b8.sgn = 1'b0; b8.x = 8'h55; b8.y = 8'h33; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", {31'd0, b8.in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, b8.out_valid}, 32'd0);
    chk("midrst_z", {16'd0, b8.z}, 32'd0);
    op8(1'b0, 8'd7, 8'd9, r, lat, rdy_hi);
    chk("after_rst_7x9", {16'd0, r}, 32'd63);
    idle8("idle_r1");

    // reset coinciding with a handshake keeps the block idle
    rst = 1'b1; b8.in_valid = 1'b1; b8.x = 8'd3; b8.y = 8'd3;
    @(posedge clk); #1;
    rst = 1'b0; b8.in_valid = 1'b0;
    chk("rst_vs_hs", {31'd0, b8.in_ready}, 32'd1);

    // exhaustive N=4, back-to-back
    bad_lat = 0;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          b4.sgn = s[0]; b4.x = a[3:0]; b4.y = b[3:0]; b4.in_valid = 1'b1;
          w = 0;
          while (!b4.in_ready && w < 20) begin @(posedge clk); #1; w++; end
          @(posedge clk); #1;
          b4.in_valid = 1'b0;
          w = 0;
          while (!b4.out_valid && w < 20) begin @(posedge clk); #1; w++; end
          if (w != 4) bad_lat++;
          if (s == 1) begin
            sa = a[3:0]; sb = b[3:0];
            p = int'(sa) * int'(sb);
          end else begin
            p = a * b;
          end
          chk(s ? "n4_signed" : "n4_unsigned", {24'd0, b4.z}, {24'd0, p[7:0]});
          if (s == 0 && a == 15 && b == 15)
            chk("n4_15x15", {24'd0, b4.z}, 32'hE1);
        end
      end
    end
    chk("n4_latency_errs", bad_lat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
